tinyqv_uart_tx: RTL and testbench



---
 rtl/tinyqv_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_tinyqv_uart_tx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_uart_tx.sv
// tinyqv_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Ports: clk, rstn (sync, active-low); TinyQV data bus addr_in,
//   data_write_n, data_read_n, data_in, data_ready, data_out;
//   uart_txd (idle high); irq (TX-empty, only with TINYQV_UART_TX_IRQ_EN).
module tinyqv_uart_tx #(
  parameter logic [27:0] BASE_ADDR   = 28'h8000000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [27:0] addr_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  input  logic [31:0] data_in,
  output logic        data_ready,
  output logic [31:0] data_out,
  output logic        uart_txd,
  output logic        irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;

  state_t        state;
  logic [15:0]   div;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          irq_en;

  logic          sel, wr, rd;
  logic          full, empty, busy;
  logic          push, pop, bit_end;
  logic [1:0]    off;
  logic [31:0]   status;
  logic          unused;

  assign sel   = addr_in[27:4] == BASE_ADDR[27:4];
  assign off   = addr_in[3:2];
  assign wr    = data_write_n != 2'b11;
  assign rd    = data_read_n != 2'b11;
  assign full  = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign busy  = (state != S_IDLE) || !empty;

  assign unused = &{1'b0, data_in[31:16], addr_in[1:0]};

  assign status = {23'b0, irq_en, 4'(count),
                   1'b0, empty, full, busy};

  always_comb begin
    data_ready = 1'b0;
    data_out   = '0;
    push       = 1'b0;
    if (sel && (wr || rd)) begin
      data_ready = 1'b1;
      if (wr && off == 2'd0) begin
        data_ready = !full;
        push       = !full;
      end
      if (rd) begin
        unique case (off)
          2'd1:    data_out = status;
          2'd2:    data_out = {16'b0, div};
          default: data_out = '0;
        endcase
      end
    end
  end

  // A pop loads the shifter: from IDLE, or straight out of STOP
  // so that queued frames follow with no idle gap.
  assign bit_end = baud_cnt == '0;
  assign pop = !empty &&
               (state == S_IDLE ||
                (state == S_STOP && bit_end));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div <= DEFAULT_DIV;
    end else if (sel && wr && off == 2'd2) begin
      div <= data_in[15:0];
    end
  end

`ifdef TINYQV_UART_TX_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (sel && wr && off == 2'd1)
        irq_en <= data_in[8];
      irq <= irq_en && empty &&
             state == S_IDLE;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      uart_txd <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if (state != S_IDLE && !bit_end)
        baud_cnt <= baud_cnt - 16'd1;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= div;
            uart_txd <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= div;
            bit_idx  <= '0;
            uart_txd <= shift[0];
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= div;
            shift    <= shift >> 1;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= S_STOP;
            end else begin
              uart_txd <= shift[1];
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift    <= mem[rd_ptr];
              baud_cnt <= div;
              uart_txd <= 1'b0;
              state    <= S_START;
            end else begin
              state    <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinyqv_uart_tx.sv
// tb_tinyqv_uart_tx: randomized bench for tinyqv_uart_tx.
// Frame-level reference model predicts txd, irq, ready and readback.
module tb_tinyqv_uart_tx;
  localparam logic [27:0] BASE  = 28'h8000000;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic [27:0] addr_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_in;
  logic        data_ready;
  logic [31:0] data_out;
  logic        uart_txd;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  bit mon_on = 0;

  tinyqv_uart_tx dut (
    .clk          (clk),
    .rstn         (rstn),
    .addr_in      (addr_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_in      (data_in),
    .data_ready   (data_ready),
    .data_out     (data_out),
    .uart_txd     (uart_txd),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a byte queue plus the frame currently on the
  // line, described as start time and bit period.
  logic [7:0] mq[$];
  bit         m_act = 0;
  int         m_pos = 0;
  int         m_per = 1;
  logic [9:0] m_frm = '1;
  int         m_div = 103;
  bit         m_en  = 0;
  bit         m_irq = 0;

  always @(posedge clk) begin : p_model
    logic       s, w, acc, fin;
    logic [7:0] b;
    if (!rstn) begin
      mq.delete();
      m_act = 0;
      m_pos = 0;
      m_div = 103;
      m_en  = 0;
      m_irq = 0;
    end else begin
      s   = addr_in[27:4] == BASE[27:4];
      w   = data_write_n != 2'b11;
      acc = s && w && addr_in[3:2] == 2'd0 &&
            mq.size() < DEPTH;
      m_irq = m_en && mq.size() == 0 && !m_act;
      fin = m_act && (m_pos + 1 == 10 * m_per);
      if ((!m_act || fin) && mq.size() > 0) begin
        b     = mq.pop_front();
        m_frm = {1'b1, b, 1'b0};
        m_act = 1;
        m_pos = 0;
        m_per = m_div + 1;
      end else if (fin) begin
        m_act = 0;
      end else if (m_act) begin
        m_pos++;
      end
      if (acc)
        mq.push_back(data_in[7:0]);
      if (s && w && addr_in[3:2] == 2'd2)
        m_div = int'(data_in[15:0]);
`ifdef TINYQV_UART_TX_IRQ_EN
      if (s && w && addr_in[3:2] == 2'd1)
        m_en = data_in[8];
`endif
    end
  end

  function automatic logic exp_txd();
    return m_act ? m_frm[m_pos / m_per] : 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] o);
    logic [31:0] r;
    r = '0;
    case (o)
      2'd1: begin
        r[0]   = m_act || mq.size() != 0;
        r[1]   = mq.size() == DEPTH;
        r[2]   = mq.size() == 0;
        r[7:4] = 4'(mq.size());
        r[8]   = m_en;
      end
      2'd2: r[15:0] = 16'(m_div);
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic exp_rdy(input logic [27:0] a,
                                   input bit w);
    if (a[27:4] != BASE[27:4]) return 1'b0;
    if (w && a[3:2] == 2'd0) return mq.size() < DEPTH;
    return 1'b1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("txd", uart_txd, exp_txd());
      chk("irq", irq, m_irq);
      if (data_read_n == 2'b11 && data_write_n == 2'b11) begin
        chk("idle_rdy", data_ready, 1'b0);
        chk("idle_dout", data_out, 32'h0);
      end
    end
  end

  task automatic bus(input logic [27:0] a, input bit w,
                     input logic [31:0] d,
                     output logic [31:0] got,
                     output logic [31:0] exp,
                     output int stall);
    bit done;
    done  = 0;
    stall = 0;
    got   = '0;
    exp   = '0;
    addr_in = a;
    data_in = d;
    if (w) data_write_n = 2'($urandom_range(0, 2));
    else   data_read_n  = 2'($urandom_range(0, 2));
    while (!done) begin
      @(negedge clk);
      chk("rdy", data_ready, exp_rdy(a, w));
      if (data_ready) begin
        got  = data_out;
        exp  = exp_rd(a[3:2]);
        done = 1;
      end else if (++stall > 400) begin
        chk("rdy_timeout", data_ready, 1'b1);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
  endtask

  task automatic wr(input logic [3:0] o, input logic [31:0] d);
    logic [31:0] g, e;
    int s;
    bus(BASE | 28'(o), 1'b1, d, g, e, s);
  endtask

  task automatic rd(input logic [3:0] o, output logic [31:0] g);
    logic [31:0] e;
    int s;
    bus(BASE | 28'(o), 1'b0, 32'h0, g, e, s);
    chk("rd_model", g, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_act || mq.size() != 0) && n < 3000) begin
      step(1);
      n++;
    end
    chk("idle_in_time", 32'(n < 3000), 32'h1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] g, e;
    logic [9:0]  fr;
    int          s;
    rstn = 1'b0;
    addr_in = BASE;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    data_in = '0;
    step(3);
    rstn = 1'b1;
    mon_on = 1;

    // reset state
    rd(4'h4, g);
    chk("t1_status", g, 32'h4);
    rd(4'h8, g);
    chk("t1_div", g, 32'd103);

    // single frame, DIV=3
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h55);
    fr = 10'b1_0101_0101_0;
    @(negedge clk);
    chk("t2_pre", uart_txd, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("t2_bit", uart_txd, fr[k / 4]);
    end
    @(negedge clk);
    chk("t2_post", uart_txd, 1'b1);
    step(1);
    rd(4'h4, g);
    chk("t2_status", g, 32'h4);

    // back-to-back frames, DIV=0, overfill the FIFO
    wr(4'h8, 32'd0);
    for (int i = 0; i < 5; i++)
      wr(4'h0, 32'($urandom_range(0, 255)));
    bus(BASE, 1'b1, 32'hC3, g, e, s);
    chk("t3_stalled", 32'(s > 0), 32'h1);
    wait_idle();

    // out-of-window access and reserved register
    addr_in = BASE + 28'h10;
    data_in = 32'hAA;
    data_write_n = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_oow_wr", data_ready, 1'b0);
    end
    step(1);
    data_write_n = 2'b11;
    data_read_n  = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_oow_rd", data_ready, 1'b0);
    end
    step(1);
    data_read_n = 2'b11;
    rd(4'h4, g);
    chk("t4_status", g, 32'h4);
    rd(4'hC, g);
    chk("t4_rsvd", g, 32'h0);
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'h8, g);
    chk("t4_div", g, 32'h0);

    // reset in the middle of DATA
    wr(4'h8, 32'd7);
    wr(4'h0, 32'hA5);
    step(20);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    @(negedge clk);
    chk("t5_txd", uart_txd, 1'b1);
    step(1);
    rd(4'h4, g);
    chk("t5_status", g, 32'h4);
    rd(4'h8, g);
    chk("t5_div", g, 32'd103);

`ifdef TINYQV_UART_TX_IRQ_EN
    // TX-empty interrupt
    wr(4'h4, 32'h100);
    wr(4'h8, 32'd1);
    wr(4'h0, 32'h3C);
    @(negedge clk);
    chk("t6_irq_hold", irq, 1'b1);
    @(negedge clk);
    chk("t6_irq_busy", irq, 1'b0);
    step(1);
    wait_idle();
    @(negedge clk);
    chk("t6_irq_stop", irq, 1'b0);
    @(negedge clk);
    chk("t6_irq_idle", irq, 1'b1);
    step(1);
    rd(4'h4, g);
    chk("t6_status", g, 32'h104);
    wr(4'h0, 32'h81);
    @(negedge clk);
    chk("t6_irq_push", irq, 1'b1);
    @(negedge clk);
    chk("t6_irq_clr", irq, 1'b0);
    step(1);
    wait_idle();
`endif

    // randomized traffic
    wr(4'h8, 32'd2);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: wr(4'h0, $urandom);
        3: rd(4'({2'($urandom_range(0, 3)), 2'b00}), g);
        4: wr($urandom_range(0, 1) ? 4'h4 : 4'hC, $urandom);
        default: begin
          if (!m_act && mq.size() == 0)
            wr(4'h8, 32'($urandom_range(0, 4)));
        end
      endcase
      step($urandom_range(0, 12));
    end
    wait_idle();
    step(2);
    rd(4'h4, g);
    chk("end_busy", g[2:0], 3'b100);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
